// File: rtl/mseq_ctrl.sv
// mseq_ctrl: run controller around the combinational mfun m-sequence step.
// It latches seed, poly and len, steps the state once per cycle and streams the
// feedback bits. The bits are also collected into seq, and period records the
// first return of the state to the seed.

// mfun: one Fibonacci-style shift step. The feedback bit is the parity of the
// state bits selected by type_f. It is shifted in at the LSB and is also the
// generated bit.
module mfun #(
  parameter int W = 5
) (
  input  logic [W-1:0] fase,
  input  logic [W-1:0] type_f,
  output logic [W-1:0] fase_new,
  output logic         sum
);
  assign sum      = ^(fase & type_f);
  assign fase_new = {fase[W-2:0], sum};
endmodule

module mseq_ctrl #(
  parameter int W      = 5,
  parameter int MAXLEN = 31,
  parameter int CW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [W-1:0]      seed,
  input  logic [W-1:0]      poly,
  input  logic [CW-1:0]     len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [MAXLEN-1:0] seq,
  output logic [CW-1:0]     period
);
  localparam logic [CW-1:0] LEN_MAX = CW'(MAXLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  fase_r, poly_r, seed_r;
  logic [CW-1:0] len_r, cnt, cnt_inc, len_c;
  logic [W-1:0]  fase_new;
  logic          sum;

  mfun #(.W(W)) u_mfun (
    .fase    (fase_r),
    .type_f  (poly_r),
    .fase_new(fase_new),
    .sum     (sum)
  );

  assign cnt_inc = cnt + 1'b1;

  // A len of 0, or any len beyond the longest sequence, means a full-length run.
  always_comb begin
    len_c = len;
    if (len == '0 || int'(len) > MAXLEN) len_c = LEN_MAX;
  end

  // Run FSM. All outputs are registered here.
  // The DONE cycle ignores start, so it is the one dead cycle between runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      seq       <= '0;
      period    <= '0;
      cnt       <= '0;
      fase_r    <= '0;
      poly_r    <= '0;
      seed_r    <= '0;
      len_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          bit_valid <= 1'b0;
          if (start) begin
            if (seed != '0) begin
              fase_r <= seed;
              seed_r <= seed;
              poly_r <= poly;
              len_r  <= len_c;
              cnt    <= '0;
              seq    <= '0;
              period <= '0;
              err    <= 1'b0;
              busy   <= 1'b1;
              state  <= RUN;
            end else begin
              // The all-zero state would lock mfun up, so the start is refused.
              err  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            // Abort: the partial seq, period and cnt are kept, and done is not pulsed.
            busy      <= 1'b0;
            bit_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            fase_r    <= fase_new;
            bit_out   <= sum;
            bit_valid <= 1'b1;
            seq       <= {seq[MAXLEN-2:0], sum};
            cnt       <= cnt_inc;
            if (fase_new == seed_r && period == '0) period <= cnt_inc;
            if (cnt_inc == len_r) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          bit_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          bit_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mseq_ctrl.sv
// tb_mseq_ctrl: directed bench for mseq_ctrl with a small reference model of the step.
module tb_mseq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0;
  logic [4:0]  seed = '0, poly = '0, len = '0;
  logic        busy, done, err, bit_out, bit_valid;
  logic [30:0] seq;
  logic [4:0]  period;

  int          n_chk = 0, n_fail = 0;
  logic [30:0] last_seq;

  mseq_ctrl #(.W(5), .MAXLEN(31), .CW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .seed(seed), .poly(poly),
    .len(len), .busy(busy), .done(done), .err(err), .bit_out(bit_out),
    .bit_valid(bit_valid), .seq(seq), .period(period)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference step: feedback is the parity of the tapped bits, shifted in at the LSB.
  function automatic logic [5:0] ref_step(input logic [4:0] f, input logic [4:0] p);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 5; i++) if (p[i]) b = b ^ f[i];
    return {b, f[3:0], b};
  endfunction

  // One run. stopk > 0 raises stop for edge stopk. poke > 0 pulses start with another
  // seed at edge poke (RUN) and at edge L+1 (DONE).
  task automatic run_check(input string tag, input logic [4:0] s, input logic [4:0] p,
                           input logic [4:0] l, input int stopk, input int poke);
    int          L, ngen, nv, nd, done_k, last_v, bad_busy, exp_per;
    logic [4:0]  st;
    logic [5:0]  r;
    logic [30:0] exp_seq;
    logic        exp_bits[32];
    logic        exp_busy;
    L = (l == 5'd0) ? 31 : int'(l);
    ngen = (stopk > 0) ? stopk - 1 : L;
    st = s; exp_seq = '0; exp_per = 0;
    for (int n = 1; n <= ngen; n++) begin
      r = ref_step(st, p);
      exp_bits[n] = r[5];
      st = r[4:0];
      exp_seq = {exp_seq[29:0], r[5]};
      if (st == s && exp_per == 0) exp_per = n;
    end
    seed = s; poly = p; len = l; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; seed = ~s;
    nv = 0; nd = 0; done_k = 0; last_v = 0; bad_busy = 0;
    for (int k = 1; k <= L + 2; k++) begin
      if (k == stopk) stop = 1'b1;
      if (poke > 0 && stopk == 0 && (k == poke || k == L + 1)) begin
        start = 1'b1; seed = 5'h07;
      end
      @(posedge clk); #1 stop = 1'b0; start = 1'b0;
      @(negedge clk);
      if (bit_valid) begin
        nv++; last_v = k;
        if (nv <= ngen) chk({tag, " bit"}, 32'(bit_out), 32'(exp_bits[nv]));
      end
      if (done) begin nd++; done_k = k; end
      exp_busy = (stopk > 0) ? (k < stopk) : (k < L);
      if (busy !== exp_busy) bad_busy++;
    end
    chk({tag, " nvalid"}, 32'(nv), 32'(ngen));
    chk({tag, " ndone"}, 32'(nd), (stopk > 0) ? 32'd0 : 32'd1);
    chk({tag, " busy_errs"}, 32'(bad_busy), 32'd0);
    if (stopk == 0) begin
      chk({tag, " done_cycle"}, 32'(done_k), 32'(L));
      chk({tag, " last_valid"}, 32'(last_v), 32'(L));
    end
    chk({tag, " seq"}, 32'(seq), 32'(exp_seq));
    chk({tag, " period"}, 32'(period), 32'(exp_per));
    chk({tag, " err"}, 32'(err), 32'd0);
    last_seq = exp_seq;
  endtask

  initial begin
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done_err_valid", {29'd0, done, err, bit_valid}, 32'd0);
    chk("rst seq", 32'(seq), 32'd0);
    chk("rst period", 32'(period), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_check("maxlen", 5'b10101, 5'b11101, 5'd0, 0, 0);
    run_check("short", 5'b00001, 5'b10010, 5'd4, 0, 0);

    // zero seed: refused, err held, done pulses once, outputs kept
    seed = 5'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("zseed err", 32'(err), 32'd1);
    chk("zseed done", 32'(done), 32'd1);
    chk("zseed busy_valid", {30'd0, busy, bit_valid}, 32'd0);
    @(negedge clk);
    chk("zseed done_fall", 32'(done), 32'd0);
    chk("zseed err_hold", 32'(err), 32'd1);
    chk("zseed busy_valid2", {30'd0, busy, bit_valid}, 32'd0);
    chk("zseed seq_kept", 32'(seq), 32'(last_seq));

    run_check("clr_err", 5'b00001, 5'b11101, 5'd3, 0, 0);
    run_check("stop10", 5'b00110, 5'b10100, 5'd31, 10, 0);
    run_check("stop31", 5'b10101, 5'b11101, 5'd0, 31, 0);
    run_check("poke", 5'b10011, 5'b11101, 5'd6, 0, 3);
    run_check("b2b", 5'b00001, 5'b01001, 5'd5, 0, 0);

    // async reset between edges at step 12
    seed = 5'b10101; poly = 5'b11101; len = 5'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst flags", {28'd0, done, err, bit_valid, bit_out}, 32'd0);
    chk("arst seq", 32'(seq), 32'd0);
    chk("arst period", 32'(period), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_check("post_rst", 5'b11000, 5'b10010, 5'd7, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
